// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared widths, FSM state encoding and broadcast default for the config loader
package config_pkg;
  localparam int CFG_WORD_W     = 32;
  localparam int CFG_BYTE_W     = 8;
  localparam int BCAST_ADDR_DEF = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    CHK    = 2'd2,
    COMMIT = 2'd3
  } cfg_state_e;
endpackage

// File: rtl/cfg_strobe_decode.sv
// rtl/cfg_strobe_decode.sv - frame address to one-hot / all-ones tile write-enable vector
// addr_ok is set for in-range tile addresses and for the broadcast address.
module cfg_strobe_decode
  import config_pkg::*;
#(
  parameter int NUM_TILES  = 16,
  parameter int BCAST_ADDR = BCAST_ADDR_DEF
) (
  input  logic [CFG_BYTE_W-1:0] addr,
  output logic [NUM_TILES-1:0]  en,
  output logic                  addr_ok
);

  always_comb begin
    en = '0;
    if (addr == CFG_BYTE_W'(BCAST_ADDR)) begin
      en = '1;
    end else begin
      for (int i = 0; i < NUM_TILES; i++) begin
        if (addr == CFG_BYTE_W'(i)) en[i] = 1'b1;
      end
    end
    addr_ok = |en;
  end

endmodule

// File: rtl/config_loader.sv
// rtl/config_loader.sv - host byte stream to framed 32-bit tile config writes with per-tile strobe
// Optional trailing XOR checksum byte is enabled by defining CFG_CHECKSUM_EN.
module config_loader
  import config_pkg::*;
#(
  parameter int NUM_TILES  = 16,
  parameter int BCAST_ADDR = BCAST_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CFG_BYTE_W-1:0] in_data,
  input  logic                  cfg_abort,
  output logic [CFG_WORD_W-1:0] config_data,
  output logic [NUM_TILES-1:0]  config_en,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic [7:0]            err_count
);

  cfg_state_e              state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [CFG_BYTE_W-1:0]   addr_q, addr_d;
  logic [CFG_WORD_W-1:0]   word_q, word_d;
  logic [CFG_WORD_W-1:0]   data_q, data_d;
  logic [NUM_TILES-1:0]    en_q, en_d;
  logic [15:0]             fc_q, fc_d;
  logic [7:0]              ec_q, ec_d;
  logic [NUM_TILES-1:0]    dec_en;
  logic                    dec_ok;
  logic                    chk_ok;
  logic                    accept;

  assign in_ready    = (state_q != COMMIT);
  assign accept      = in_valid && in_ready;
  assign busy        = (state_q != IDLE);
  assign config_data = data_q;
  assign config_en   = en_q;
  assign frame_count = fc_q;
  assign err_count   = ec_q;

  cfg_strobe_decode #(
    .NUM_TILES (NUM_TILES),
    .BCAST_ADDR(BCAST_ADDR)
  ) u_decode (
    .addr   (addr_q),
    .en     (dec_en),
    .addr_ok(dec_ok)
  );

`ifdef CFG_CHECKSUM_EN
  // Running XOR over ADDR..CHK; a consistent frame leaves zero.
  logic [CFG_BYTE_W-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (accept) chk_d = (state_q == IDLE) ? in_data : (chk_q ^ in_data);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chk_q <= '0;
    else        chk_q <= chk_d;
  end

  assign chk_ok = (chk_q == '0);
`else
  assign chk_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    word_d  = word_q;
    data_d  = data_q;
    en_d    = '0;
    fc_d    = fc_q;
    ec_d    = ec_q;
    case (state_q)
      IDLE: if (accept) begin
        addr_d  = in_data;
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: if (accept) begin
        word_d = {in_data, word_q[CFG_WORD_W-1:CFG_BYTE_W]};
        cnt_d  = cnt_q + 2'd1;
`ifdef CFG_CHECKSUM_EN
        if (cnt_q == 2'd3) state_d = CHK;
`else
        if (cnt_q == 2'd3) state_d = COMMIT;
`endif
      end
      CHK: if (accept) state_d = COMMIT;
      COMMIT: begin
        if (dec_ok && chk_ok) begin
          data_d = word_q;
          en_d   = dec_en;
          fc_d   = fc_q + 16'd1;
        end else if (ec_q != 8'hFF) begin
          ec_d = ec_q + 8'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort never cancels a commit already in progress; it only rewinds framing.
    if (cfg_abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      data_q  <= '0;
      en_q    <= '0;
      fc_q    <= '0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      data_q  <= data_d;
      en_q    <= en_d;
      fc_q    <= fc_d;
      ec_q    <= ec_d;
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - directed self-checking bench for config_loader
module tb_config_loader;
  localparam int NT = 16;
`ifdef CFG_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam int FLEN = CHK_EN ? 6 : 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        cfg_abort;
  logic [31:0] config_data;
  logic [15:0] config_en;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  config_loader #(.NUM_TILES(NT), .BCAST_ADDR(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .cfg_abort  (cfg_abort),
    .config_data(config_data),
    .config_en  (config_en),
    .busy       (busy),
    .frame_count(frame_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit gaps     = 1'b0;

  logic [15:0] obs_en[$];
  logic [31:0] obs_d[$];
  logic [15:0] exp_en[$];
  logic [31:0] exp_d[$];
  logic [15:0] m_fc   = '0;
  logic [7:0]  m_ec   = '0;
  logic [31:0] m_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (config_en != '0) begin
      obs_en.push_back(config_en);
      obs_d.push_back(config_data);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the byte's handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int k;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 2);
      if (g > 0) begin
        in_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      n_assert++;
      n_fail++;
      $error("FAIL ready_timeout observed=in_ready_low expected=in_ready_high");
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] w,
                            input logic [7:0] chk_err, input bit keep);
    logic [7:0] c;
    bit ok;
    c = a ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24] ^ chk_err;
    send_byte(a);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    if (CHK_EN) send_byte(c);
    if (!keep) in_valid = 1'b0;
    ok = ((a < NT) || (a == 8'hFF)) && (!CHK_EN || chk_err == 8'h00);
    if (ok) begin
      m_fc++;
      m_data = w;
      exp_en.push_back((a == 8'hFF) ? 16'hFFFF : (16'(1) << a));
      exp_d.push_back(w);
    end else if (m_ec != 8'hFF) begin
      m_ec++;
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_frame_count"}, frame_count, m_fc);
    check({tag, "_err_count"}, err_count, m_ec);
    check({tag, "_config_data"}, config_data, m_data);
    check({tag, "_strobe_n"}, obs_en.size(), exp_en.size());
    while (obs_en.size() > 0 && exp_en.size() > 0) begin
      check({tag, "_strobe_en"}, obs_en.pop_front(), exp_en.pop_front());
      check({tag, "_strobe_data"}, obs_d.pop_front(), exp_d.pop_front());
    end
    obs_en.delete(); obs_d.delete(); exp_en.delete(); exp_d.delete();
  endtask

  initial begin
    int c0;
    logic [7:0]  a;
    logic [31:0] w;
    logic [7:0]  ce;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_abort = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_config_data", config_data, 32'h0);
    check("rst_config_en", config_en, 16'h0);
    check("rst_frame_count", frame_count, 16'h0);
    check("rst_err_count", err_count, 8'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    // 1: reset mid-frame, then the first real frame
    send_byte(8'h03);
    send_byte(8'hEF);
    in_valid = 1'b0;
    check("t1_busy_mid", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t1_async_busy", busy, 1'b0);
    check("t1_async_en", config_en, 16'h0);
    check("t1_async_data", config_data, 32'h0);
    check("t1_async_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_frame(8'h03, 32'hDEADBEEF, 8'h00, 1'b0);
    check("t1_commit_ready", in_ready, 1'b0);
    check("t1_commit_busy", busy, 1'b1);
    check("t1_en_early", config_en, 16'h0);
    @(negedge clk);
    check("t1_en", config_en, 16'h0008);
    check("t1_data", config_data, 32'hDEADBEEF);
    check("t1_fc", frame_count, 16'd1);
    @(negedge clk);
    check("t1_en_off", config_en, 16'h0);
    check_model("t1");

    // 2: back-to-back frames with in_valid held lose one cycle
    c0 = cyc;
    send_frame(8'h01, 32'h11223344, 8'h00, 1'b1);
    send_frame(8'h02, 32'h55667788, 8'h00, 1'b0);
    check("t2_cycles", cyc - c0, 2 * FLEN + 1);
    settle();
    check("t2_fc", frame_count, 16'd3);
    check_model("t2");

    // 3: out-of-range address rejected, next frame commits
    send_frame(8'h10, 32'hCAFEF00D, 8'h00, 1'b0);
    settle();
    check("t3_err", err_count, 8'd1);
    check_model("t3_bad");
    send_frame(8'h04, 32'h0BADC0DE, 8'h00, 1'b0);
    settle();
    check_model("t3_good");

    // 4: checksum mismatch then a good frame to tile 0
`ifdef CFG_CHECKSUM_EN
    send_frame(8'h00, 32'h04030201, 8'h04, 1'b0);
    settle();
    check_model("t4_badchk");
`endif
    send_frame(8'h00, 32'h04030201, 8'h00, 1'b0);
    settle();
    check_model("t4_good");

    // 5: broadcast, abort mid-frame, abort during commit
    send_frame(8'hFF, 32'hA5A55A5A, 8'h00, 1'b0);
    settle();
    check_model("t5_bcast");
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    cfg_abort = 1'b1;
    in_data   = 8'h33;
    @(negedge clk);
    cfg_abort = 1'b0;
    in_valid  = 1'b0;
    check("t5_abort_busy", busy, 1'b0);
    send_frame(8'h06, 32'h87654321, 8'h00, 1'b0);
    settle();
    check_model("t5_after_abort");
    send_frame(8'h07, 32'h13579BDF, 8'h00, 1'b0);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    check("t5_abort_commit_busy", busy, 1'b0);
    check("t5_abort_commit_en", config_en, 16'h0080);
    @(negedge clk);
    check_model("t5_abort_commit");

    // 6: random frames with random valid gaps, then error saturation
    gaps = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 254)) : 8'($urandom_range(0, 15));
      w  = $urandom;
      ce = (CHK_EN && $urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(a, w, ce, 1'b0);
      settle();
    end
    check_model("t6_random");
    gaps = 1'b0;
    for (int i = 0; i < 260; i++) send_frame(8'h20, 32'(i), 8'h00, 1'b0);
    settle();
    check("t6_err_sat", err_count, 8'hFF);
    check_model("t6_sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
